// File: rtl/hsync_detect.sv
// hsync_detect
//   Receive-side horizontal timing recovery. Samples an active-low hsync and
//   a data-enable, recovers the active pixel x coordinate, measures line
//   period / sync width / active width and declares lock once the measured
//   timing has repeated for LOCK_LINES consecutive lines.
//
// Ports
//   i_clk        pixel clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_hsync      horizontal sync, active low
//   i_hde        data enable, active high
//   o_de         i_hde delayed to line up with o_x
//   o_x          index of the current active pixel within the line
//   o_htotal     last measured line period in clocks
//   o_hsync_len  last measured sync-low width in clocks
//   o_hactive    last measured DE-high clocks per line
//   o_locked     timing stable
//   o_err        one-cycle pulse on mismatch or overflow while tracking
module hsync_detect #(
    parameter int CW         = 10,
    parameter int LOCK_LINES = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_hsync,
    input  logic          i_hde,
    output logic          o_de,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_htotal,
    output logic [CW-1:0] o_hsync_len,
    output logic [CW-1:0] o_hactive,
    output logic          o_locked,
    output logic          o_err
);

    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [3:0]    LOCK_TGT = 4'(LOCK_LINES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TRACK   = 2'd2
    } state_t;

    state_t        state_r;
    logic          hs_r;
    logic          hs_d_r;
    logic          de_r;
    logic [CW-1:0] clk_cnt_r;
    logic [CW-1:0] sync_cnt_r;
    logic [CW-1:0] sync_meas_r;
    logic [CW-1:0] de_cnt_r;
    logic [3:0]    lock_cnt_r;

    logic          fall_s;
    logic          rise_s;
    logic          overflow_s;
    logic [CW-1:0] period_s;
    logic          match_s;
    logic [3:0]    lock_next_s;

    // Edge detection, overflow and the measurement of the line just ended
    always_comb begin
        fall_s      = hs_d_r & ~hs_r;
        rise_s      = ~hs_d_r & hs_r;
        overflow_s  = (clk_cnt_r == CNT_MAX);
        period_s    = clk_cnt_r + CNT_ONE;
        match_s     = (period_s == o_htotal) &&
                      (sync_meas_r == o_hsync_len) &&
                      (de_cnt_r == o_hactive);
        if (lock_cnt_r == LOCK_TGT) begin
            lock_next_s = LOCK_TGT;
        end else begin
            lock_next_s = lock_cnt_r + 4'd1;
        end
    end

    // Input sampling; hsync registers idle high so reset does not fake an edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hs_r   <= 1'b1;
            hs_d_r <= 1'b1;
            de_r   <= 1'b0;
        end else begin
            hs_r   <= i_hsync;
            hs_d_r <= hs_r;
            de_r   <= i_hde;
        end
    end

    // Per-line counters, restarted on every sync falling edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_cnt_r   <= CNT_ZERO;
            sync_cnt_r  <= CNT_ZERO;
            sync_meas_r <= CNT_ZERO;
            de_cnt_r    <= CNT_ZERO;
        end else begin
            if (fall_s) begin
                clk_cnt_r <= CNT_ZERO;
            end else if (clk_cnt_r != CNT_MAX) begin
                clk_cnt_r <= clk_cnt_r + CNT_ONE;
            end else begin
                clk_cnt_r <= clk_cnt_r;
            end

            // The fall cycle is itself the first low sample, hence the 1
            if (fall_s) begin
                sync_cnt_r <= CNT_ONE;
            end else if (!hs_r && (sync_cnt_r != CNT_MAX)) begin
                sync_cnt_r <= sync_cnt_r + CNT_ONE;
            end else begin
                sync_cnt_r <= sync_cnt_r;
            end

            if (rise_s) begin
                sync_meas_r <= sync_cnt_r;
            end else begin
                sync_meas_r <= sync_meas_r;
            end

            if (fall_s) begin
                de_cnt_r <= CNT_ZERO;
            end else if (de_r && (de_cnt_r != CNT_MAX)) begin
                de_cnt_r <= de_cnt_r + CNT_ONE;
            end else begin
                de_cnt_r <= de_cnt_r;
            end
        end
    end

    // Pixel output: o_x is the count of DE samples already seen this line
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_de <= 1'b0;
            o_x  <= CNT_ZERO;
        end else begin
            o_de <= de_r;
            if (fall_s) begin
                o_x <= CNT_ZERO;
            end else begin
                o_x <= de_cnt_r;
            end
        end
    end

    // Lock state machine; a fall always takes priority over overflow
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= IDLE;
            lock_cnt_r  <= 4'd0;
            o_htotal    <= CNT_ZERO;
            o_hsync_len <= CNT_ZERO;
            o_hactive   <= CNT_ZERO;
            o_locked    <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_err <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (fall_s) begin
                        state_r <= MEASURE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MEASURE: begin
                    if (fall_s) begin
                        o_htotal    <= period_s;
                        o_hsync_len <= sync_meas_r;
                        o_hactive   <= de_cnt_r;
                        lock_cnt_r  <= 4'd0;
                        state_r     <= TRACK;
                    end else if (overflow_s) begin
                        o_locked <= 1'b0;
                        o_err    <= 1'b1;
                        state_r  <= IDLE;
                    end else begin
                        state_r <= MEASURE;
                    end
                end
                TRACK: begin
                    if (fall_s) begin
                        if (match_s) begin
                            lock_cnt_r <= lock_next_s;
                            if (lock_next_s == LOCK_TGT) begin
                                o_locked <= 1'b1;
                            end else begin
                                o_locked <= o_locked;
                            end
                        end else begin
                            o_htotal    <= period_s;
                            o_hsync_len <= sync_meas_r;
                            o_hactive   <= de_cnt_r;
                            lock_cnt_r  <= 4'd0;
                            o_locked    <= 1'b0;
                            o_err       <= 1'b1;
                        end
                        state_r <= TRACK;
                    end else if (overflow_s) begin
                        o_locked <= 1'b0;
                        o_err    <= 1'b1;
                        state_r  <= IDLE;
                    end else begin
                        state_r <= TRACK;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hsync_detect.sv
// Directed bench for hsync_detect: nominal lock, glitch, missing sync,
// mid-line reset, sync width change, plus a LOCK_LINES=1 instance.
module tb_hsync_detect;

    logic       clk;
    logic       rst_n;
    logic       hs;
    logic       de;

    logic       out_de,  out_de1;
    logic [9:0] out_x,   out_x1;
    logic [9:0] htotal,  htotal1;
    logic [9:0] hsl,     hsl1;
    logic [9:0] hact,    hact1;
    logic       locked,  locked1;
    logic       err,     err1;

    int passed;
    int total;
    int err_seen;
    int x_bad;
    int exp_x;
    int last_run;

    hsync_detect #(.CW(10), .LOCK_LINES(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_hsync(hs), .i_hde(de),
        .o_de(out_de), .o_x(out_x), .o_htotal(htotal), .o_hsync_len(hsl),
        .o_hactive(hact), .o_locked(locked), .o_err(err)
    );

    hsync_detect #(.CW(10), .LOCK_LINES(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_hsync(hs), .i_hde(de),
        .o_de(out_de1), .o_x(out_x1), .o_htotal(htotal1), .o_hsync_len(hsl1),
        .o_hactive(hact1), .o_locked(locked1), .o_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    endtask

    // One clock: sample outputs on the falling edge, then drive new inputs
    task automatic step(input logic h, input logic d);
        @(negedge clk);
        if (err === 1'b1) err_seen++;
        if (out_de === 1'b1) begin
            if (out_x !== exp_x[9:0]) x_bad++;
            exp_x++;
        end else begin
            if (exp_x != 0) last_run = exp_x;
            exp_x = 0;
        end
        hs = h;
        de = d;
    endtask

    // DE on counts 0..799, sync low from count 840 for sw clocks
    task automatic line(input int len, input int sw);
        for (int c = 0; c < len; c++) begin
            step(!((c >= 840) && (c < 840 + sw)), (c < 800));
        end
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        err_seen = 0;
        x_bad    = 0;
        exp_x    = 0;
        last_run = 0;
        hs       = 1'b1;
        de       = 1'b0;
        rst_n    = 1'b1;
        #2;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_de",      32'(out_de), 32'd0);
        check("rst_x",       32'(out_x),  32'd0);
        check("rst_htotal",  32'(htotal), 32'd0);
        check("rst_hsl",     32'(hsl),    32'd0);
        check("rst_hact",    32'(hact),   32'd0);
        check("rst_locked",  32'(locked), 32'd0);
        check("rst_err",     32'(err),    32'd0);
        rst_n = 1'b1;

        // Nominal timing, 8 lines
        for (int l = 1; l <= 8; l++) begin
            line(890, 10);
            if (l == 1) check("nom_idle_htotal", 32'(htotal), 32'd0);
            if (l == 2) begin
                check("nom_htotal",   32'(htotal),  32'd890);
                check("nom_hsl",      32'(hsl),     32'd10);
                check("nom_hact",     32'(hact),    32'd800);
                check("nom_lock_l2",  32'(locked),  32'd0);
                check("nom_lock1_l2", 32'(locked1), 32'd0);
            end
            if (l == 3) check("nom_lock1_l3", 32'(locked1), 32'd1);
            if (l == 5) check("nom_lock_l5",  32'(locked),  32'd0);
            if (l == 6) check("nom_lock_l6",  32'(locked),  32'd1);
        end
        check("nom_err",     32'(err_seen), 32'd0);
        check("nom_x_seq",   32'(x_bad),    32'd0);
        check("nom_de_run",  32'(last_run), 32'd800);

        // Glitch: one 889-clock line
        err_seen = 0;
        line(889, 10);
        check("gl_short_err", 32'(err_seen), 32'd0);
        line(890, 10);
        check("gl_err1",    32'(err_seen), 32'd1);
        check("gl_lock1",   32'(locked),   32'd0);
        check("gl_htot889", 32'(htotal),   32'd889);
        line(890, 10);
        check("gl_err2",    32'(err_seen), 32'd2);
        check("gl_htot890", 32'(htotal),   32'd890);
        repeat (3) line(890, 10);
        check("gl_lock_3",  32'(locked),   32'd0);
        line(890, 10);
        check("gl_lock_4",  32'(locked),   32'd1);
        check("gl_err_end", 32'(err_seen), 32'd2);

        // Missing sync
        err_seen = 0;
        repeat (1100) step(1'b1, 1'b0);
        check("ms_err",    32'(err_seen), 32'd1);
        check("ms_locked", 32'(locked),   32'd0);
        check("ms_htotal", 32'(htotal),   32'd890);
        check("ms_hsl",    32'(hsl),      32'd10);
        check("ms_hact",   32'(hact),     32'd800);
        err_seen = 0;
        for (int l = 1; l <= 6; l++) begin
            line(890, 10);
            if (l == 5) check("ms_relock_l5", 32'(locked), 32'd0);
            if (l == 6) check("ms_relock_l6", 32'(locked), 32'd1);
        end
        check("ms_relock_err", 32'(err_seen), 32'd0);

        // Reset at pixel 400 of a locked line
        for (int c = 0; c < 400; c++) step(1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mr_de",      32'(out_de),  32'd0);
        check("mr_x",       32'(out_x),   32'd0);
        check("mr_htotal",  32'(htotal),  32'd0);
        check("mr_hsl",     32'(hsl),     32'd0);
        check("mr_hact",    32'(hact),    32'd0);
        check("mr_locked",  32'(locked),  32'd0);
        check("mr_locked1", 32'(locked1), 32'd0);
        repeat (3) step(1'b1, 1'b0);
        rst_n = 1'b1;
        for (int l = 1; l <= 6; l++) begin
            line(890, 10);
            if (l == 1) check("mr_idle_htotal", 32'(htotal), 32'd0);
            if (l == 5) check("mr_lock_l5",     32'(locked), 32'd0);
            if (l == 6) begin
                check("mr_lock_l6", 32'(locked), 32'd1);
                check("mr_htotal2", 32'(htotal), 32'd890);
            end
        end

        // Sync width change to 20 clocks
        err_seen = 0;
        line(890, 20);
        check("sw_first_err", 32'(err_seen), 32'd0);
        line(890, 20);
        check("sw_err",    32'(err_seen), 32'd1);
        check("sw_hsl",    32'(hsl),      32'd20);
        check("sw_htotal", 32'(htotal),   32'd890);
        check("sw_hact",   32'(hact),     32'd800);
        check("sw_locked", 32'(locked),   32'd0);
        repeat (3) line(890, 20);
        check("sw_lock_3", 32'(locked),   32'd0);
        line(890, 20);
        check("sw_lock_4", 32'(locked),   32'd1);
        check("sw_err_end", 32'(err_seen), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hsync_detect.md
Name: hsync_detect

Overview:
- Receive-side counterpart of the LCD horizontal timing generator.
- Samples an incoming active-low hsync and data-enable pair, and recovers the pixel x coordinate.
- Measures line period, sync width and active width, and declares lock once the timing has been stable for a programmable number of lines.
- Sits between a video source (camera or loopback of our own LCD timing) and downstream pixel processing.

Parameters:
- CW, 10, width of all counters and measurement outputs.
- LOCK_LINES, 4, consecutive identical lines required before o_locked asserts (range 1..15).

Ports:
- i_clk  input  1  pixel clock; all logic on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_hsync  input  1  horizontal sync, active low, synchronous to i_clk.
- i_hde  input  1  data enable, active high.
- o_de  output  1  i_hde delayed to align with o_x.
- o_x  output  CW  index of current active pixel within the line.
- o_htotal  output  CW  last measured line period in clocks.
- o_hsync_len  output  CW  last measured sync-low width in clocks.
- o_hactive  output  CW  last measured count of DE-high clocks per line.
- o_locked  output  1  timing stable.
- o_err  output  1  one-cycle pulse on mismatch or overflow while tracking.

Behaviour:
- Reset (async assert, sync release): every register 0 except r_hs and r_hs_d, which reset to 1 (idle level). Outputs reset to o_de=0, o_x=0, o_htotal=0, o_hsync_len=0, o_hactive=0, o_locked=0, o_err=0. State goes to IDLE. Reset mid-line discards all partial counts.
- Input stage: r_hs<=i_hsync, r_hs_d<=r_hs, r_de<=i_hde.
- Line edge: fall = r_hs_d & ~r_hs. Rise = ~r_hs_d & r_hs.
- clk_cnt:
  - Cleared to 0 on fall; otherwise increments.
  - Saturates at 2^CW-1.
- sync_cnt:
  - Cleared to 1 on fall; increments while r_hs=0.
  - Its value is latched into sync_meas on rise.
- de_cnt:
  - Cleared on fall; increments when r_de=1.
  - o_de<=r_de and o_x<=de_cnt (with fall-clear priority), so o_x runs 0..hactive-1 on the o_de-high cycles.
  - Pin-to-o_x latency is 2 clocks.
- On each fall, the line just ended is measured as:
  - period = clk_cnt+1
  - swidth = sync_meas
  - active = de_cnt
- State machine:
  - IDLE: on the first fall, go to MEASURE. No outputs are updated.
  - MEASURE: on the next fall, load o_htotal, o_hsync_len and o_hactive with the measured values, set lock_cnt=0, and go to TRACK.
  - TRACK, on each fall:
    - If all three measured values equal the current outputs: lock_cnt increments, saturating at LOCK_LINES. o_locked<=1 when lock_cnt reaches LOCK_LINES.
    - Otherwise: load the new values into the outputs, lock_cnt=0, o_locked<=0, and o_err pulses for 1 clock.
- Overflow: if clk_cnt reaches 2^CW-1 in MEASURE or TRACK (missing sync):
  - o_locked<=0, o_err pulses once, state goes to IDLE.
  - The measurement outputs hold their last values.
- A sync pulse still low at the next fall cannot occur. A fall while r_hs is already low is impossible by the edge definition.
- DE high during sync is counted in active and is not flagged.
- Simultaneous fall and overflow: fall wins, and clk_cnt is cleared.

Test Plan:
- Nominal timing: drive 890-clock lines with sync low on counts 840..849 and DE on counts 0..799, for 8 lines.
  - o_htotal=890, o_hsync_len=10, o_hactive=800.
  - o_locked rises at the 6th fall (1 IDLE + 1 MEASURE + 4 matches).
  - o_x=0..799 while o_de=1.
- Glitch: after lock, shorten one line to 889 clocks.
  - o_err pulses once, o_locked=0, o_htotal=889.
  - On the following normal line a mismatch repeats (890): o_err pulses again.
  - o_locked returns 4 matching lines later.
- Missing sync: hold i_hsync high for 1100 clocks after lock.
  - At clk_cnt=1023: o_locked=0, one o_err pulse, state IDLE.
  - Outputs stay at 890/10/800.
- Reset mid-line: assert i_rst_n=0 at pixel 400 of a locked line.
  - All outputs immediately 0.
  - After release, relock is required (6 falls).
- Sync width change: switch the sync width to 20 clocks with the period unchanged.
  - o_hsync_len=20 and o_err pulses at that line's closing fall.
  - Lock is reacquired after 4 lines.
- LOCK_LINES=1 build with nominal timing: o_locked asserts at the 3rd fall.
